adiw_sbiw_seq: RTL and testbench
================================

Name: adiw_sbiw_seq

Overview:
- Byte-serial controller that executes the 16-bit word instructions ADIW/SBIW (Rd+1:Rd ± K) on one shared 8-bit carry look-ahead adder section, instead of a full 16-bit adder.
- Sequences the low byte, then the high byte with the stored carry, then publishes the 16-bit result and the AVR SREG flags C, Z, N, V, S.
- Sits between the instruction decoder / register-file read ports and the 8-bit adder instance.
- The adder itself is external: this block drives its operands and carry-in, and samples its sum and carry-out.

Parameters:
- IMM_W, 6: width of the immediate K. K is zero-extended to 16 bits.

Ports:
- cp2  input  1  core clock; all state updates on the rising edge.
- ireset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- op_sub  input  1  0 = ADIW, 1 = SBIW; captured with start.
- opa  input  16  word operand Rd+1:Rd; captured with start.
- imm  input  IMM_W  immediate K; captured with start.
- add_a  output  8  operand A to the shared 8-bit adder.
- add_b  output  8  operand B to the shared 8-bit adder (inverted byte for SBIW).
- add_ci  output  1  carry-in to the shared 8-bit adder.
- add_s  input  8  sum from the adder (combinational path from add_a/add_b/add_ci).
- add_co  input  1  carry-out from the adder.
- busy  output  1  high in states LO and HI.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  16  registered 16-bit result.
- flag_c, flag_z, flag_n, flag_v, flag_s  output  1 each  registered SREG flags.

Behaviour:
- Reset:
  - When ireset=1 at a rising edge, state goes to IDLE.
  - busy=0, done=0, result=0x0000, all flags=0.
  - Operand/carry holding registers are cleared.
  - Reset overrides start.
  - Reset while in LO, HI or DONE aborts the operation; no done pulse is produced.
- Operand capture:
  - Capture occurs at the edge where start=1 and the state is IDLE or DONE.
  - The block latches A=opa, B=zero-extended imm, sub=op_sub.
- Adder drive (combinational from state and holding registers):
  - LO: add_a=A[7:0]; add_b=B[7:0] (ADIW) or ~B[7:0] (SBIW); add_ci=sub.
  - HI: add_a=A[15:8]; add_b=B[15:8] or ~B[15:8]; add_ci=stored low-byte carry.
  - IDLE and DONE: add_a=0x00, add_b=0x00, add_ci=0.
- State machine:
  - IDLE: if start, go to LO; otherwise stay in IDLE.
  - LO: store add_s into the low byte and add_co into the carry register; go to HI.
  - HI: register result={add_s, low byte} and update all flags; go to DONE.
  - DONE: done=1. If start, capture the new operands and go to LO (back-to-back, no bubble); otherwise go to IDLE.
- Latency: start accepted at edge N gives LO after N, HI after N+1, and done=1 for the cycle after edge N+2. Throughput is one operation per 3 cycles.
- start in LO or HI is ignored; it is not queued.
- Flags are computed at the HI edge from R=result, A15=A[15] and co=add_co:
  - C: co for ADIW; ~co for SBIW (borrow).
  - Z: R==0x0000.
  - N: R15.
  - V: ~A15 & R15 for ADIW; A15 & ~R15 for SBIW.
  - S: N ^ V.
- Wrap-around:
  - Results are modulo 2^16.
  - 0xFFFF+1 = 0x0000 with C=1.
  - 0x0000−1 = 0xFFFF with C=1.
- result and flags hold their values until the next HI edge or reset.

Test Plan:
1. ADIW opa=0x00FF, imm=1 -> done 3 cycles after start; result=0x0100, C=0, Z=0, N=0, V=0, S=0; the HI-cycle add_ci observed as 1.
2. ADIW opa=0xFFFF, imm=1 -> result=0x0000, C=1, Z=1, N=0, V=0, S=0.
3. ADIW opa=0x7FFF, imm=1 -> result=0x8000, N=1, V=1, S=0, C=0. SBIW opa=0x8000, imm=1 -> result=0x7FFF, V=1, N=0, S=1, C=0.
4. SBIW opa=0x0000, imm=63 -> result=0xFFC1, C=1, N=1, V=0, S=1, Z=0. SBIW opa=0x0001, imm=1 -> result=0x0000, Z=1, C=0.
5. Back-to-back: start held high continuously with ADIW 0x1234+5 then SBIW 0x1000−16 -> done pulses 3 cycles apart, results 0x1239 then 0x0FF0. A start pulse in LO or HI produces no extra done.
6. ireset=1 during HI -> next cycle state IDLE, busy=0, done never pulses, result=0x0000, all flags=0. A new start after reset completes normally.

Source files
------------

// File: rtl/adiw_sbiw_seq.sv
// ADIW/SBIW word add/subtract, run one byte at a time on a shared external 8-bit adder.
// Latency: start accepted at edge N -> LO, HI, then done pulses for the cycle after edge N+2.
// Backpressure: start is taken only in IDLE or DONE; it is dropped (not queued) while busy.
module adiw_sbiw_seq #(
  parameter int IMM_W = 6
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [15:0]      opa,
  input  logic [IMM_W-1:0] imm,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_ci,
  input  logic [7:0]       add_s,
  input  logic             add_co,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_s
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;
  logic [7:0]  lo_q;
  logic        c_q;
  logic        accept;
  logic [15:0] b_sel;
  logic [15:0] res_w;
  logic        fc, fz, fn, fv, fs;

  // SBIW is A + ~B + 1: invert the immediate and force carry-in 1 on the low byte.
  assign b_sel  = sub_q ? ~b_q : b_q;
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == LO) || (state == HI);
  assign done   = (state == DONE);

  // Flags from the word as it is formed in HI: high byte straight from the adder.
  assign res_w = {add_s, lo_q};
  assign fc    = sub_q ? ~add_co : add_co;
  assign fz    = (res_w == 16'h0000);
  assign fn    = res_w[15];
  assign fv    = sub_q ? (a_q[15] & ~res_w[15]) : (~a_q[15] & res_w[15]);
  assign fs    = fn ^ fv;

  // Adder operand steering: low byte in LO, high byte with the stored carry in HI.
  always_comb begin
    add_a  = 8'h00;
    add_b  = 8'h00;
    add_ci = 1'b0;
    case (state)
      LO: begin
        add_a  = a_q[7:0];
        add_b  = b_sel[7:0];
        add_ci = sub_q;
      end
      HI: begin
        add_a  = a_q[15:8];
        add_b  = b_sel[15:8];
        add_ci = c_q;
      end
      default: ;
    endcase
  end

  // Next-state logic; DONE re-launches directly into LO when start is present.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LO : IDLE;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    state_nxt = start ? LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cp2) begin
    if (ireset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, low-byte/carry holding, and the registered result and flags.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      sub_q  <= 1'b0;
      lo_q   <= 8'h00;
      c_q    <= 1'b0;
      result <= 16'h0000;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      flag_s <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= opa;
        b_q   <= 16'(imm);
        sub_q <= op_sub;
      end
      if (state == LO) begin
        lo_q <= add_s;
        c_q  <= add_co;
      end
      if (state == HI) begin
        result <= res_w;
        flag_c <= fc;
        flag_z <= fz;
        flag_n <= fn;
        flag_v <= fv;
        flag_s <= fs;
      end
    end
  end

endmodule

// File: tb/tb_adiw_sbiw_seq.sv
// Directed bench for adiw_sbiw_seq with a behavioural 8-bit adder and a scoreboard.
// Stimulus pushes hand-computed results; a negedge monitor pops on every done pulse.
// Flags are packed {C,Z,N,V,S}.
module tb_adiw_sbiw_seq;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] opa = 16'h0000;
  logic [5:0]  imm = 6'd0;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_c, flag_z, flag_n, flag_v, flag_s;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  f;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;
  int   ndone = 0;
  int   npush = 0;

  adiw_sbiw_seq #(.IMM_W(6)) dut (
    .cp2(cp2), .ireset(ireset), .start(start), .op_sub(op_sub), .opa(opa), .imm(imm),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_s(flag_s)
  );

  // External 8-bit adder
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};

  always #5 cp2 = ~cp2;
  always @(posedge cp2) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge cp2) begin
    if (done === 1'b1) begin
      exp_t e;
      ndone++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.c);
        chk("result", {16'h0, result}, {16'h0, e.r});
        chk("flags", {27'h0, flag_c, flag_z, flag_n, flag_v, flag_s}, {27'h0, e.f});
      end
    end
  end

  task automatic step();
    @(posedge cp2);
    #1;
  endtask

  // Drive one request at the next edge; optionally keep start high afterwards.
  task automatic issue(input logic sub, input logic [15:0] a, input logic [5:0] k,
                       input logic [15:0] er, input logic [4:0] ef,
                       input bit hold, input bit push);
    exp_t e;
    op_sub = sub;
    opa    = a;
    imm    = k;
    start  = 1'b1;
    if (push) begin
      e.r = er;
      e.f = ef;
      e.c = cyc + 3;
      q.push_back(e);
      npush++;
    end
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain_queue", q.size(), 0);
    step();
  endtask

  initial begin
    // Reset state
    step();
    step();
    @(negedge cp2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_c, flag_z, flag_n, flag_v, flag_s}, 0);
    chk("rst_add_drive", {add_a, add_b, add_ci}, 0);
    step();
    ireset = 1'b0;
    step();

    // 1: carry ripples from low byte into high byte
    issue(1'b0, 16'h00FF, 6'd1, 16'h0100, 5'b00000, 1'b0, 1'b1);
    @(negedge cp2);
    chk("lo_busy", busy, 1);
    chk("lo_drive", {add_a, add_b, add_ci}, {8'hFF, 8'h01, 1'b0});
    @(negedge cp2);
    chk("hi_drive", {add_a, add_b, add_ci}, {8'h00, 8'h00, 1'b1});
    drain();

    // 2: wrap to zero
    issue(1'b0, 16'hFFFF, 6'd1, 16'h0000, 5'b11000, 1'b0, 1'b1);
    drain();

    // 3: signed overflow both directions
    issue(1'b0, 16'h7FFF, 6'd1, 16'h8000, 5'b00110, 1'b0, 1'b1);
    drain();
    issue(1'b1, 16'h8000, 6'd1, 16'h7FFF, 5'b00011, 1'b0, 1'b1);
    @(negedge cp2);
    chk("sbiw_lo_drive", {add_a, add_b, add_ci}, {8'h00, 8'hFE, 1'b1});
    drain();

    // 4: borrow below zero, and subtract to zero
    issue(1'b1, 16'h0000, 6'd63, 16'hFFC1, 5'b10101, 1'b0, 1'b1);
    drain();
    issue(1'b1, 16'h0001, 6'd1, 16'h0000, 5'b01000, 1'b0, 1'b1);
    drain();

    // 5: back-to-back with start held high; second op taken in DONE
    issue(1'b0, 16'h1234, 6'd5, 16'h1239, 5'b00000, 1'b1, 1'b1);
    op_sub = 1'b1;
    opa    = 16'h1000;
    imm    = 6'd16;
    begin
      exp_t e;
      e.r = 16'h0FF0;
      e.f = 5'b00000;
      e.c = cyc + 5;
      q.push_back(e);
      npush++;
    end
    step();
    step();
    step();
    start = 1'b0;
    drain();

    // 5b: start held through LO and HI is ignored
    issue(1'b0, 16'h0010, 6'd2, 16'h0012, 5'b00000, 1'b1, 1'b1);
    step();
    step();
    start = 1'b0;
    drain();
    repeat (4) step();

    // 6: reset during HI aborts; no done pulse
    issue(1'b0, 16'h0001, 6'd2, 16'h0000, 5'b00000, 1'b0, 1'b0);
    step();
    ireset = 1'b1;
    step();
    ireset = 1'b0;
    @(negedge cp2);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {flag_c, flag_z, flag_n, flag_v, flag_s}, 0);
    repeat (5) step();
    issue(1'b0, 16'h0001, 6'd2, 16'h0003, 5'b00000, 1'b0, 1'b1);
    drain();
    repeat (3) step();

    chk("done_count", ndone, npush);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
